pipe_stage_buf: RTL

Generic parametrised pipeline-stage register for the pipelined CPU. It carries a control bundle and a data payload between two stages with a valid/ready handshake, a two-entry skid buffer, synchronous flush and bubble semantics. Bubble semantics means control bits read zero whenever the stage is empty. It is the drop-in successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Each instance is sized by parameters.

---
 rtl/pipe_stage_buf_if.sv | 27 ++
 rtl/pipe_stage_buf.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle between two pipeline stages around one pipe_stage_buf.
// The slave modport is the buffer's view; the master modport is the view
// of the surrounding stages, which drive the beat and the stall.
interface pipe_stage_buf_if #(
    parameter int unsigned CTRL_W = 5,
    parameter int unsigned DATA_W = 105
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occupancy
    );

    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Inter-stage register with a two-entry skid buffer (main + skid).
// in_ready is registered, so out_ready never reaches in_ready
// combinationally. The only logic after the registers is the bubble
// gating of out_ctrl/out_data, which depends on the main valid bit alone.
module pipe_stage_buf #(
    parameter int unsigned CTRL_W     = 5,
    parameter int unsigned DATA_W     = 105,
    parameter bit          CLEAR_DATA = 1'b1
) (
    input  logic                   clk,
    input  logic                   startin,
    input  logic                   flush,
    pipe_stage_buf_if.slave        bus
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    // The state encoding equals the beat count, so it doubles as occupancy.
    logic [1:0]        state_q, state_d;
    logic              main_vld_q, main_vld_d;
    logic              skid_vld_q, skid_vld_d;
    logic              in_ready_q, in_ready_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic in_fire;
    logic out_fire;

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = main_vld_q & bus.out_ready;

    // Next-state: reset over flush over handshake.
    always_comb begin
        state_d     = state_q;
        main_vld_d  = main_vld_q;
        skid_vld_d  = skid_vld_q;
        in_ready_d  = in_ready_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (startin) begin
            state_d     = EMPTY;
            main_vld_d  = 1'b0;
            skid_vld_d  = 1'b0;
            in_ready_d  = 1'b1;
            main_ctrl_d = '0;
            main_data_d = '0;
            skid_ctrl_d = '0;
            skid_data_d = '0;
        end else if (flush) begin
            // Any beat accepted this cycle is discarded along with the held ones.
            state_d     = EMPTY;
            main_vld_d  = 1'b0;
            skid_vld_d  = 1'b0;
            in_ready_d  = 1'b1;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (CLEAR_DATA) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_ctrl_d = bus.in_ctrl;
                        main_data_d = bus.in_data;
                        main_vld_d  = 1'b1;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = bus.in_ctrl;
                        main_data_d = bus.in_data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new beat behind main.
                        skid_ctrl_d = bus.in_ctrl;
                        skid_data_d = bus.in_data;
                        skid_vld_d  = 1'b1;
                        in_ready_d  = 1'b0;
                        state_d     = FULL;
                    end else if (out_fire) begin
                        main_vld_d  = 1'b0;
                        main_ctrl_d = '0;
                        if (CLEAR_DATA) begin
                            main_data_d = '0;
                        end
                        state_d     = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_vld_d  = 1'b0;
                        skid_ctrl_d = '0;
                        if (CLEAR_DATA) begin
                            skid_data_d = '0;
                        end
                        in_ready_d  = 1'b1;
                        state_d     = ONE;
                    end
                end
                default: begin
                    state_d    = EMPTY;
                    main_vld_d = 1'b0;
                    skid_vld_d = 1'b0;
                    in_ready_d = 1'b1;
                end
            endcase
        end
    end

    // State registers; reset handled in the next-state logic.
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        main_vld_q  <= main_vld_d;
        skid_vld_q  <= skid_vld_d;
        in_ready_q  <= in_ready_d;
        main_ctrl_q <= main_ctrl_d;
        main_data_q <= main_data_d;
        skid_ctrl_q <= skid_ctrl_d;
        skid_data_q <= skid_data_d;
    end

    // Outputs: registered, with control (and optionally data) gated on bubbles.
    always_comb begin
        bus.in_ready  = in_ready_q;
        bus.out_valid = main_vld_q;
        bus.occupancy = state_q;
        bus.out_ctrl  = main_vld_q ? main_ctrl_q : '0;
        bus.out_data  = (CLEAR_DATA && !main_vld_q) ? '0 : main_data_q;
    end

    // The skid valid bit is implied by state; it is kept as a distinct
    // register so each entry carries its own valid flag.
    logic unused_skid_vld;
    assign unused_skid_vld = skid_vld_q;

endmodule
